serial_demux8: RTL and testbench



---
 rtl/serial_demux_pkg.sv | 6 +
 rtl/demux1x8.sv | 14 +
 rtl/serial_demux8.sv | 60 ++++++
 tb/tb_serial_demux8.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_demux_pkg.sv
// serial_demux_pkg: shared state encoding and default sizes for the serial demux receiver
package serial_demux_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  localparam int DEF_N  = 8;
  localparam int DEF_SW = 3;
endpackage

// File: rtl/demux1x8.sv
// demux1x8: one-hot slot write-enable decoder, the inverse of the 8:1 mux
module demux1x8
  import serial_demux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = DEF_SW
) (
  input  logic [SW-1:0] sel,
  input  logic          en,
  output logic [N-1:0]  we
);
  // Route the enable onto the single slot addressed by sel
  always_comb we = en ? (N'(1) << sel) : '0;
endmodule

// File: rtl/serial_demux8.sv
// serial_demux8: serial-to-parallel frame receiver with registered byte commit and done strobe
module serial_demux8
  import serial_demux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  out,
  output logic          busy,
  output logic          done
);
  localparam logic [SW:0] LAST = (SW+1)'(N-1);
  state_t        state, state_n;
  logic [SW:0]   count, count_n;
  logic [N-1:0]  stage, stage_n, we;
  logic          go, commit;
  assign go     = start && !abort;
  assign sel    = (state == RECV) ? count[SW-1:0] : '0;
  assign busy   = state == RECV;
  assign done   = state == DONE;
  assign commit = (state == RECV) && !abort && (count == LAST);
  demux1x8 #(.N(N), .SW(SW)) u_demux (
    .sel(sel),
    .en((state == RECV) || go),
    .we(we)
  );
  // Next state and count: RECV walks the slots, IDLE/DONE accept a new start at slot 0
  always_comb begin
    state_n = state;
    count_n = count;
    stage_n = (stage & ~we) | (we & {N{in}});
    if (state == RECV) begin
      count_n = count + (SW+1)'(1);
      state_n = abort ? IDLE : (count == LAST) ? DONE : RECV;
    end else begin
      count_n = go ? (SW+1)'(1) : '0;
      state_n = go ? RECV : IDLE;
    end
  end
  // State, counter, staging and committed output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      stage <= '0;
      out   <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      stage <= stage_n;
      if (commit) out <= stage_n;
    end
  end
endmodule

// File: tb/tb_serial_demux8.sv
// tb_serial_demux8: randomized self-checking bench for serial_demux8 with a byte-level reference
module tb_serial_demux8;
  logic       clk = 0, rst = 1, start = 0, abort = 0, in_drv = 0, loop = 0;
  logic [7:0] tx = 0;
  logic       in;
  logic [2:0] sel;
  logic [7:0] out;
  logic       busy, done;
  int         checks = 0, errors = 0;

  assign in = loop ? tx[sel] : in_drv;

  serial_demux8 dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in(in),
    .sel(sel), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] b, input int abort_at, input logic [7:0] smask,
                           output logic done_end, output logic [7:0] out_end,
                           output int busy_n, output int done_mid, output int sel_bad);
    start = 1; abort = 0; in_drv = b[0];
    tick;
    busy_n = 0; done_mid = 0; sel_bad = 0;
    for (int i = 1; i < 8; i++) begin
      in_drv = b[i];
      start  = smask[i];
      abort  = (i == abort_at);
      busy_n += int'(busy);
      done_mid += int'(done);
      if (i <= abort_at && sel !== 3'(i)) sel_bad++;
      tick;
    end
    start = 0; abort = 0;
    done_end = done; out_end = out;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (out !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%h sel=%0d busy=%b done=%b, want 00 0 0 0", out, sel, busy, done);
    end
    @(negedge clk); rst = 0;
    tick;
  endtask

  task automatic test_basic;
    logic d; logic [7:0] o; int bn, dm, sb;
    run_frame(8'b01001101, 8, 8'h00, d, o, bn, dm, sb);
    checks++;
    if (d !== 1'b1 || o !== 8'h4D) begin
      errors++;
      $display("FAIL basic: done=%b out=%h, want 1 4d", d, o);
    end
    checks++;
    if (bn != 7 || dm != 0 || sb != 0) begin
      errors++;
      $display("FAIL basic_timing: busy_cycles=%0d early_done=%0d sel_errs=%0d, want 7 0 0", bn, dm, sb);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== 8'h4D) begin
      errors++;
      $display("FAIL basic_strobe: done=%b busy=%b out=%h, want 0 0 4d", done, busy, out);
    end
  endtask

  task automatic test_back_to_back;
    logic d; logic [7:0] o; int bn, dm, sb;
    run_frame(8'hA5, 8, 8'h00, d, o, bn, dm, sb);
    checks++;
    if (d !== 1'b1 || o !== 8'hA5 || bn != 7 || dm != 0) begin
      errors++;
      $display("FAIL b2b_first: done=%b out=%h busy=%0d, want 1 a5 7", d, o, bn);
    end
    run_frame(8'h3C, 8, 8'h00, d, o, bn, dm, sb);
    checks++;
    if (d !== 1'b1 || o !== 8'h3C || bn != 7 || dm != 0 || sb != 0) begin
      errors++;
      $display("FAIL b2b_second: done=%b out=%h busy=%0d early_done=%0d sel_errs=%0d, want 1 3c 7 0 0",
               d, o, bn, dm, sb);
    end
    tick;
  endtask

  task automatic test_abort;
    logic d; logic [7:0] o; int bn, dm, sb;
    run_frame(8'h5A, 4, 8'h00, d, o, bn, dm, sb);
    checks++;
    if (d !== 1'b0 || dm != 0 || o !== 8'h3C) begin
      errors++;
      $display("FAIL abort_out: done=%b mid_done=%0d out=%h, want 0 0 3c", d, dm, o);
    end
    checks++;
    if (bn != 4 || sb != 0) begin
      errors++;
      $display("FAIL abort_busy: busy_cycles=%0d sel_errs=%0d, want 4 0", bn, sb);
    end
    tick;
    run_frame(8'hFF, 8, 8'h00, d, o, bn, dm, sb);
    checks++;
    if (d !== 1'b1 || o !== 8'hFF) begin
      errors++;
      $display("FAIL abort_next: done=%b out=%h, want 1 ff", d, o);
    end
    tick;
  endtask

  task automatic test_ignored_start;
    logic d; logic [7:0] o; int bn, dm, sb, extra;
    run_frame(8'h96, 8, 8'b0010_0100, d, o, bn, dm, sb);
    checks++;
    if (d !== 1'b1 || o !== 8'h96 || bn != 7 || dm != 0 || sb != 0) begin
      errors++;
      $display("FAIL ignored_start: done=%b out=%h busy=%0d mid_done=%0d sel_errs=%0d, want 1 96 7 0 0",
               d, o, bn, dm, sb);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick; extra += int'(done) + int'(busy); end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_start_tail: extra activity=%0d, want 0", extra);
    end
  endtask

  task automatic test_async_reset;
    int late;
    start = 1; in_drv = 1;
    tick;
    start = 0;
    for (int i = 1; i < 6; i++) tick;
    checks++;
    if (sel !== 3'd6 || busy !== 1'b1 || out !== 8'h96) begin
      errors++;
      $display("FAIL async_pre: sel=%0d busy=%b out=%h, want 6 1 96", sel, busy, out);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (out !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%h sel=%0d busy=%b done=%b, want 00 0 0 0", out, sel, busy, done);
    end
    #3 rst = 0;
    late = 0;
    for (int i = 0; i < 10; i++) begin tick; late += int'(done) + int'(busy); end
    checks++;
    if (late != 0 || out !== 8'h00) begin
      errors++;
      $display("FAIL async_after: activity=%0d out=%h, want 0 00", late, out);
    end
  endtask

  task automatic test_round_trip;
    int n;
    loop = 1;
    tx = 8'($urandom);
    start = 1;
    tick;
    for (int f = 0; f < 1000; f++) begin
      start = 0;
      n = 0;
      while (!done && n < 12) begin tick; n++; end
      checks++;
      if (done !== 1'b1 || n != 7 || out !== tx) begin
        errors++;
        $display("FAIL round_trip[%0d]: done=%b cycles=%0d out=%h, want 1 7 %h", f, done, n, out, tx);
      end
      tx = 8'($urandom);
      if ($urandom_range(1) == 0) begin
        tick;
        start = 1;
      end else start = 1;
      tick;
    end
    start = 0;
    loop = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_abort;
    test_ignored_start;
    test_async_reset;
    test_round_trip;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
